zero_cross_period: RTL and testbench

- Parametrised successor to the single-edge zero-crossing detector in the frequency-estimator front end.
- Classifies each enabled sample with a programmable hysteresis band and detects falling, rising or both-edge crossings.
- Rejects crossings that arrive too soon after the previous one (glitch gap).
- Measures the sample count between qualifying crossings, which feeds the frequency estimator directly.

---
 rtl/zc_pkg.sv | 18 +
 rtl/zc_hyst_classifier.sv | 55 +++++
 rtl/zero_cross_period.sv | 104 ++++++++++
 tb/tb_zero_cross_period.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/zc_pkg.sv
// Shared encodings for the zero-crossing period detector.
package zc_pkg;

    // Edge selection encodings; the raw value 2'b11 is folded onto ZC_FALL by the top level.
    typedef enum logic [1:0] {
        ZC_FALL = 2'b00,
        ZC_RISE = 2'b01,
        ZC_BOTH = 2'b10
    } zc_mode_t;

    // Hysteresis classifier states.
    typedef enum logic [1:0] {
        ZC_UNK = 2'b00,
        ZC_POS = 2'b01,
        ZC_NEG = 2'b10
    } zc_state_t;

endpackage

// File: rtl/zc_hyst_classifier.sv
// Hysteresis classifier: tracks which side of the +/-H band the signal last left
// and flags NEG->POS / POS->NEG transitions for the current sample.
module zc_hyst_classifier #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [W-1:0] x,
    input  logic [W-2:0] hyst,
    output logic         rise_evt,
    output logic         fall_evt
);
    import zc_pkg::*;

    zc_state_t state_reg;
    zc_state_t state_next;

    // One extra bit so that -H never overflows, even for H = 2^(W-1)-1.
    logic signed [W:0] x_ext;
    logic signed [W:0] h_pos;
    logic signed [W:0] h_neg;
    logic              above;
    logic              below;

    assign x_ext = {x[W-1], x};
    assign h_pos = {2'b00, hyst};
    assign h_neg = -h_pos;
    assign above = (x_ext > h_pos);
    assign below = (x_ext < h_neg);

    // Next-state and event decode; values inside the band hold the state.
    always_comb begin
        state_next = state_reg;
        rise_evt   = 1'b0;
        fall_evt   = 1'b0;
        if (above) begin
            state_next = ZC_POS;
            rise_evt   = (state_reg == ZC_NEG);
        end else if (below) begin
            state_next = ZC_NEG;
            fall_evt   = (state_reg == ZC_POS);
        end
    end

    // State register, advancing only on enabled samples.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ZC_UNK;
        end else if (enable) begin
            state_reg <= state_next;
        end
    end

endmodule

// File: rtl/zero_cross_period.sv
// Zero-crossing detector with edge selection, glitch-gap rejection and
// sample-count period measurement for the frequency estimator.
module zero_cross_period #(
    parameter int W       = 12,
    parameter int CNT_W   = 16,
    parameter int MIN_GAP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [W-1:0]     x,
    input  logic [1:0]       mode,
    input  logic [W-2:0]     hyst,
    output logic             flag,
    output logic             edge_dir,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             timeout
);
    import zc_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - 1'b1;
    localparam logic [CNT_W-1:0] GAP_MIN  = CNT_W'(MIN_GAP - 1);

    logic             rise_evt;
    logic             fall_evt;
    zc_mode_t         mode_reg;
    zc_mode_t         mode_eff;
    logic             mode_change;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_eff;
    logic             armed_reg;
    logic             armed_eff;
    logic             match;
    logic             qualify;

    zc_hyst_classifier #(.W(W)) u_classifier (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .x        (x),
        .hyst     (hyst),
        .rise_evt (rise_evt),
        .fall_evt (fall_evt)
    );

    // A mode change restarts the measurement, and the same-cycle event is judged
    // against the new mode with a cleared counter and disarmed state.
    always_comb begin
        mode_eff    = (mode == 2'b11) ? ZC_FALL : zc_mode_t'(mode);
        mode_change = (mode_eff != mode_reg);
        cnt_eff     = mode_change ? '0 : cnt_reg;
        armed_eff   = mode_change ? 1'b0 : armed_reg;
        match       = 1'b0;
        case (mode_eff)
            ZC_RISE: match = rise_evt;
            ZC_BOTH: match = rise_evt | fall_evt;
            default: match = fall_evt;
        endcase
        qualify = match & ((cnt_eff >= GAP_MIN) | ~armed_eff);
    end

    // Counter, arming and output registers; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            flag         <= 1'b0;
            edge_dir     <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            cnt_reg      <= '0;
            armed_reg    <= 1'b0;
            mode_reg     <= ZC_FALL;
        end else begin
            flag         <= 1'b0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            if (enable) begin
                mode_reg <= mode_eff;
                if (qualify) begin
                    flag      <= 1'b1;
                    edge_dir  <= rise_evt;
                    cnt_reg   <= '0;
                    armed_reg <= 1'b1;
                    if (armed_eff) begin
                        period       <= cnt_eff + 1'b1;
                        period_valid <= 1'b1;
                    end
                end else if (mode_change) begin
                    cnt_reg   <= '0;
                    armed_reg <= 1'b0;
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        timeout   <= 1'b1;
                        armed_reg <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_zero_cross_period.sv
// Scoreboard bench for zero_cross_period: stimulus pushes expected events from
// an index-based reference model, a monitor pops them when the DUT reports one.
module tb_zero_cross_period;
    localparam int W       = 12;
    localparam int CNT_W   = 4;
    localparam int MIN_GAP = 4;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    enable = 1'b0;
    logic signed [W-1:0]     x = '0;
    logic [1:0]              mode = 2'b00;
    logic [W-2:0]            hyst = '0;
    logic                    flag;
    logic                    edge_dir;
    logic [CNT_W-1:0]        period;
    logic                    period_valid;
    logic                    timeout;

    zero_cross_period #(.W(W), .CNT_W(CNT_W), .MIN_GAP(MIN_GAP)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .x            (x),
        .mode         (mode),
        .hyst         (hyst),
        .flag         (flag),
        .edge_dir     (edge_dir),
        .period       (period),
        .period_valid (period_valid),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit flag;
        bit dir;
        bit pv;
        int per;
        bit to;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    // Reference model: level memory plus sample indices. The counter seen by a
    // sample is the number of enabled samples since the last restart point.
    int m_lvl = 0;     // 0 unknown, 1 above band, 2 below band
    int m_k = 0;       // enabled sample index
    int m_r = 0;       // index of the sample after which the count restarted
    int m_mode = 0;
    bit m_armed = 0;

    task automatic model_reset();
        m_lvl = 0; m_armed = 0; m_mode = 0; m_r = m_k;
    endtask

    task automatic drive(input int xv, input int md, input int hv, input bit en);
        int   em, nl, cnt;
        bit   rise, fall, chg, match, q;
        exp_t e;
        @(negedge clk);
        x = xv[W-1:0]; mode = md[1:0]; hyst = hv[W-2:0]; enable = en;
        if (!en) return;
        em = (md == 3) ? 0 : md;
        nl = m_lvl;
        if (xv > hv) nl = 1;
        else if (xv < -hv) nl = 2;
        rise = (m_lvl == 2 && nl == 1);
        fall = (m_lvl == 1 && nl == 2);
        m_lvl = nl;
        m_k++;
        chg = (em != m_mode);
        if (chg) begin
            m_mode = em; m_armed = 0; m_r = m_k - 1;
        end
        cnt = m_k - 1 - m_r;
        if (cnt > MAXC) cnt = MAXC;
        match = (em == 0 && fall) || (em == 1 && rise) || (em == 2 && (rise || fall));
        q = match && (cnt >= MIN_GAP - 1 || !m_armed);
        if (q) begin
            e = '{cyc: cyc + 1, flag: 1, dir: rise, pv: m_armed, per: cnt + 1, to: 0};
            exp_q.push_back(e);
            m_armed = 1; m_r = m_k;
        end else if (chg) begin
            m_r = m_k;
        end else if (cnt + 1 == MAXC) begin
            e = '{cyc: cyc + 1, flag: 0, dir: 0, pv: 0, per: 0, to: 1};
            exp_q.push_back(e);
            m_armed = 0;
        end
    endtask

    task automatic square(input int reps, input int md, input int hv);
        for (int i = 0; i < reps; i++) begin
            for (int j = 0; j < 4; j++) drive(500, md, hv, 1);
            for (int j = 0; j < 4; j++) drive(-500, md, hv, 1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0; enable = 1; x = 12'sd500;
        @(negedge clk);
        chk("rst_flag", flag, 0);
        chk("rst_dir", edge_dir, 0);
        chk("rst_period", period, 0);
        chk("rst_pv", period_valid, 0);
        chk("rst_timeout", timeout, 0);
        reset = 1; enable = 0;
        model_reset();
    endtask

    // Monitor: consume one expectation per reported DUT event.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            chk("missed_event_cycle", cyc, e.cyc);
        end
        if (flag || period_valid || timeout) begin
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                chk("unexpected_event", 1, 0);
            end else begin
                e = exp_q.pop_front();
                $display("event cyc=%0d flag=%0b dir=%0b pv=%0b period=%0d timeout=%0b",
                         cyc, flag, edge_dir, period_valid, period, timeout);
                chk("flag", flag, e.flag);
                chk("period_valid", period_valid, e.pv);
                chk("timeout", timeout, e.to);
                if (e.flag) chk("edge_dir", edge_dir, e.dir);
                if (e.pv) chk("period", period, e.per);
            end
        end
    end

    initial begin
        int sgn, run, hv, md, xv;
        repeat (2) @(negedge clk);
        do_reset();
        // Falling edges every 8 samples.
        square(4, 0, 100);
        // Both edges: half periods of 4.
        square(4, 2, 100);
        // In-band noise between swings must not create crossings.
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 4; j++) drive(500, 0, 100, 1);
            for (int j = 0; j < 6; j++) drive((j % 2) ? 50 : -50, 0, 100, 1);
            for (int j = 0; j < 4; j++) drive(-500, 0, 100, 1);
        end
        // H = 0 with a one-sample glitch closer than the gap.
        for (int j = 0; j < 8; j++) drive(300, 0, 0, 1);
        drive(-300, 0, 0, 1);
        drive(300, 0, 0, 1);
        drive(-300, 0, 0, 1);
        for (int j = 0; j < 5; j++) drive(300, 0, 0, 1);
        // Saturation, then re-arm and measure again.
        for (int j = 0; j < 25; j++) drive(500, 0, 100, 1);
        square(3, 0, 100);
        // Enable gaps mid-period.
        for (int j = 0; j < 4; j++) drive(500, 0, 100, 1);
        for (int j = 0; j < 2; j++) drive(-500, 0, 100, 1);
        for (int j = 0; j < 10; j++) drive(500, 0, 100, 0);
        for (int j = 0; j < 2; j++) drive(-500, 0, 100, 1);
        square(2, 0, 100);
        // Reset mid-period, then the first crossing only arms.
        for (int j = 0; j < 3; j++) drive(500, 0, 100, 1);
        do_reset();
        square(2, 0, 100);
        // Extreme band: -2048 against H = 2047 must classify below the band.
        drive(500, 0, 100, 1);
        for (int j = 0; j < 4; j++) drive(-2048, 0, 2047, 1);
        for (int j = 0; j < 2; j++) drive(2047, 1, 2047, 1);
        // Randomized segments with random mode, band and enable gaps.
        hv = 100; md = 0; sgn = 1;
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 15) == 0) md = $urandom_range(0, 3);
            if ($urandom_range(0, 20) == 0) hv = $urandom_range(0, 300);
            if ($urandom_range(0, 150) == 0) do_reset();
            run = $urandom_range(1, 10);
            sgn = -sgn;
            for (int j = 0; j < run; j++) begin
                if ($urandom_range(0, 4) == 0) xv = $urandom_range(0, 2 * hv) - hv;
                else xv = sgn * (hv + 1 + $urandom_range(0, 800));
                drive(xv, md, hv, $urandom_range(0, 9) != 0);
            end
        end
        for (int j = 0; j < 4; j++) drive(0, md, hv, 0);
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
